// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit codes,
// active-low segment patterns {g,f,e,d,c,b,a} and default timing.
package seg7_pkg;

    localparam int DIV_CYCLES_DEF   = 100000;
    localparam int BLINK_CYCLES_DEF = 50000000;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment pattern decoder.
// Codes 0-9 are digits, CODE_DASH lights only g, everything else is blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // map one 4-bit code onto its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode display multiplexer. A snapshot of nums is taken
// once per frame (on the digit 3 -> 0 wrap) so updates never tear mid-frame.
// an/seg/dp are registered together so anode and segments switch on the
// same edge. A free-running blink timer can blank the whole display.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_CYCLES   = DIV_CYCLES_DEF,
    parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nums,
    input  logic        blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W   = (DIV_CYCLES   > 1) ? $clog2(DIV_CYCLES)   : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         idx;
    logic [15:0]        snap;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase_on;

    logic               div_tc;
    logic               blink_tc;
    logic [3:0]         cur_code;
    logic [6:0]         cur_seg;
    logic               dark;

    assign div_tc   = (div_cnt == DIV_W'(DIV_CYCLES - 1));
    assign blink_tc = (blink_cnt == BLINK_W'(BLINK_CYCLES - 1));
    assign cur_code = snap[{idx, 2'b00} +: 4];
    assign dark     = blink & ~phase_on;

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // digit dwell divider, digit index and once-per-frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            snap    <= 16'hFFFF;
        end else if (div_tc) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
            if (idx == 2'd3)
                snap <= nums;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // free-running blink half-period timer; runs even when blink is low
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_tc) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // registered pin drive; separator dot sits after the minutes-ones digit
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= dark ? AN_OFF : ~(4'b0001 << idx);
            seg <= cur_seg;
            dp  <= ~((idx == 2'd2) && !dark);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV_CYCLES=4, BLINK_CYCLES=64.
// Each frame is 16 cycles; expected digit patterns are written out per frame.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nums;
    logic        blink;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_DASH  = 7'b0111111;
    localparam logic [6:0] P_0     = 7'b1000000;
    localparam logic [6:0] P_1     = 7'b1111001;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_3     = 7'b0110000;
    localparam logic [6:0] P_4     = 7'b0011001;
    localparam logic [6:0] P_5     = 7'b0010010;
    localparam logic [6:0] P_9     = 7'b0010000;

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic       dp_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    seg7_scan_driver #(
        .DIV_CYCLES   (4),
        .BLINK_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .nums  (nums),
        .blink (blink),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one 16-cycle frame; s0..s3 are digit 0..3 patterns, dark = blanked by blink
    task automatic run_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input bit dark, input int chg_at,
                             input logic [15:0] chg_val);
        logic [6:0] segs [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int k = 1; k <= 16; k++) begin
            int i;
            step();
            i = (k - 1) / 4;
            if (dark) begin
                check($sformatf("%s/k%0d/an", tag, k), {12'd0, an}, 16'h000F);
                check($sformatf("%s/k%0d/dp", tag, k), {15'd0, dp}, 16'h0001);
            end else begin
                check($sformatf("%s/k%0d/an", tag, k), {12'd0, an}, {12'd0, an_exp[i]});
                check($sformatf("%s/k%0d/seg", tag, k), {9'd0, seg}, {9'd0, segs[i]});
                check($sformatf("%s/k%0d/dp", tag, k), {15'd0, dp}, {15'd0, dp_exp[i]});
            end
            if (k == chg_at)
                nums = chg_val;
        end
    endtask

    initial begin
        rst   = 1'b1;
        nums  = 16'h1234;
        blink = 1'b0;
        repeat (3) step();
        check("reset/an",  {12'd0, an},  16'h000F);
        check("reset/seg", {9'd0, seg},  16'h007F);
        check("reset/dp",  {15'd0, dp},  16'h0001);
        rst = 1'b0;

        run_frame("blank1", P_BLANK, P_BLANK, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);
        run_frame("f1234", P_4, P_3, P_2, P_1, 1'b0, 14, 16'h0000);
        run_frame("f0000", P_0, P_0, P_0, P_0, 1'b0, 5, 16'h5959);
        run_frame("f5959", P_9, P_5, P_9, P_5, 1'b0, 2, 16'hAAAA);
        run_frame("fAAAA", P_DASH, P_DASH, P_DASH, P_DASH, 1'b0, 2, 16'hFC0F);
        run_frame("fFC0F", P_BLANK, P_0, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);

        // blink phase went off at cycle 64 after reset release
        blink = 1'b1;
        repeat (2) run_frame("blk_off1", P_BLANK, P_BLANK, P_BLANK, P_BLANK, 1'b1, -1, 16'h0);
        repeat (4) run_frame("blk_on", P_BLANK, P_0, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);
        repeat (4) run_frame("blk_off2", P_BLANK, P_BLANK, P_BLANK, P_BLANK, 1'b1, -1, 16'h0);
        blink = 1'b0;
        run_frame("noblink", P_BLANK, P_0, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);

        // reset mid-frame while digit 2 is driven
        repeat (9) step();
        check("midrst/pre_an", {12'd0, an}, 16'h000B);
        rst = 1'b1;
        step();
        check("midrst/an",  {12'd0, an}, 16'h000F);
        check("midrst/seg", {9'd0, seg}, 16'h007F);
        check("midrst/dp",  {15'd0, dp}, 16'h0001);
        rst = 1'b0;
        run_frame("rec_blank", P_BLANK, P_BLANK, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);
        run_frame("rec_fc0f", P_BLANK, P_0, P_BLANK, P_BLANK, 1'b0, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Consumer end of the timer's display bus: takes the 16-bit packed digit word (four 4-bit codes, minutes-tens in bits 15:12 down to seconds-ones in bits 3:0) and drives a 4-digit common-anode seven-segment display by time-multiplexing. It latches a snapshot of the word once per scan frame so a mid-frame update never tears. It also decodes digit codes to segment patterns and adds a minutes/seconds separator dot and an optional blink. It sits between the timer output and the board pins.

## Interface
- DIV_CYCLES, 100000, clock cycles each digit is driven (1 ms at 100 MHz); minimum 2
- BLINK_CYCLES, 50000000, clock cycles per blink half-period; minimum 2
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- nums  input  16  packed digit codes; only bits 15:0 of the timer bus are consumed
- blink  input  1  1 = blank the whole display during the blink off-phase
- an  output  4  digit anodes, active-low, one-hot-low while driving; an[0] = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

## Operation
- Digit codes: 0–9 show the decimal digit; 4'hA shows a dash (g only); 4'hB–4'hF show blank.
- Active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- Scan counter div_cnt runs 0..DIV_CYCLES-1. Digit index idx (0..3) advances when div_cnt == DIV_CYCLES-1 and wraps 3→0.
- Digit idx shows snap[4*idx+3 : 4*idx]. an = ~(1<<idx). dp = 0 only when idx == 2, i.e. the separator after the minutes-ones digit. Otherwise dp = 1.
- Snapshot: snap loads nums on the cycle where idx wraps 3→0. That is the only load point. nums changes at any other time are not shown until the next frame.
- Blink: blink_cnt runs 0..BLINK_CYCLES-1 and toggles phase at wrap. Phase resets to on.
  - If blink = 1 and phase = off: an = 1111 and dp = 1. seg may carry the decoded pattern.
  - The blink counter free-runs regardless of blink, so asserting blink takes effect at once with the current phase.

## Timing
- Reset values:
  - Outputs: an = 1111, seg = 1111111, dp = 1.
  - Internal: div_cnt = 0, idx = 0, blink_cnt = 0, phase = on, snap = 16'hFFFF (blank).
- The first frame after reset shows all blanks (dp still on at idx 2). nums first appears at the first 3→0 wrap, which is 4·DIV_CYCLES cycles after reset deasserts.
- an, seg and dp are registered. They reflect idx/snap/phase with 1 cycle of latency, so all three change on the same edge and there is no ghosting between anode and segments.
- The snapshot load and the idx wrap occur on the same edge. The new frame's digit 0 therefore shows the new snap at the next registered output update.
- rst asserted mid-frame: all state returns to reset values on the next edge, and the outputs go dark that edge.
- Simultaneous idx wrap and blink phase toggle are independent. Both apply on the same edge.

## Structure
- Package seg7_pkg: code constants CODE_DASH = 4'hA and CODE_BLANK = 4'hF, the twelve segment patterns, and default DIV_CYCLES and BLINK_CYCLES.
- Sub-module seg7_decode: purely combinational 4-bit code → 7-bit active-low pattern. Instantiated once, fed by the selected snapshot nibble.
- Top holds the divider, idx, snapshot, blink counter and the output registers.

## Test plan
Bench uses DIV_CYCLES = 4 and BLINK_CYCLES = 64.
- **Reset:** hold rst for 3 cycles with nums = 16'h1234 → an = 1111, seg = 1111111, dp = 1; the next 16 cycles show blank segments with dp = 0 only while an = 1011.
- **Normal frame:** nums = 16'h1234 held → second frame gives the following, each for 4 cycles:
  - an = 1110 with seg = 0011001
  - an = 1101 with seg = 0110000
  - an = 1011 with seg = 0100100 and dp = 0
  - an = 0111 with seg = 1111001
- **No tearing:** change nums from 16'h0000 to 16'h5959 while an = 1101 → rest of that frame still shows 1000000; the next frame shows 5, 9, 5, 9 (0010010 / 0010000 alternating).
- **Dash and blank codes:** nums = 16'hAAAA → every digit shows 0111111. nums = 16'hFC0F → digits 0 and 3 blank, digit 2 blank, digit 1 shows 1000000.
- **Blink:** blink = 1 → an = 1111 and dp = 1 for 64 cycles, then scanning for 64 cycles, repeating. blink = 0 → continuous scanning.
- **Reset mid-frame:** assert rst while an = 1011 → next edge an = 1111, idx = 0, snap blank; recovery matches the reset scenario.
